// File: rtl/div_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and default width.
// Ports: none (package only).
// Imported by div_seq, div_step and div_seq_if.
package div_seq_pkg;

    // Default operand/result width; the iteration count equals this width.
    localparam int DIV_WIDTH = 32;

    // FSM state encoding shared with the CPU control unit.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage : div_seq_pkg

// File: rtl/div_seq_if.sv
// Start/done handshake and operand/result bus between the control unit and the divider.
// Signals: start, dividend, divisor (control unit -> divider);
//          busy, done, div_zero, hi, lo (divider -> control unit).
interface div_seq_if #(
    parameter int WIDTH = div_seq_pkg::DIV_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Control unit side: issues the request and reads the results.
    modport master (
        output start, dividend, divisor,
        input  busy, done, div_zero, hi, lo
    );

    // Divider side.
    modport slave (
        input  start, dividend, divisor,
        output busy, done, div_zero, hi, lo
    );
endinterface : div_seq_if

// File: rtl/div_step.sv
// One restoring-division step on unsigned magnitudes; purely combinational.
// Ports: rem_i/quot_i (current partial remainder and quotient shift register),
//        dmag_i (divisor magnitude), rem_o/quot_o (values after this step).
module div_step
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quot_i,
    input  logic [WIDTH-1:0] dmag_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quot_o
);

    // {rem, quot} shifted left by one: the dividend MSB still held in quot
    // moves into the remainder.
    logic [WIDTH:0] shifted;
    // Trial subtraction one bit wider than the operands. The remainder is
    // always below the divisor magnitude, which never exceeds 2^(WIDTH-1)
    // (|most negative value|), so the shifted remainder stays below 2^WIDTH
    // and bit WIDTH of the difference is a valid borrow/sign bit.
    logic [WIDTH:0] trial;
    logic           fits;

    always_comb begin
        shifted = {rem_i, quot_i[WIDTH-1]};
        trial   = shifted - {1'b0, dmag_i};
        fits    = ~trial[WIDTH];
        rem_o   = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_o  = {quot_i[WIDTH-2:0], fits};
    end

endmodule : div_step

// File: rtl/div_seq.sv
// Sequential signed divider (restoring, one quotient bit per clock) for the CPU DIV instruction.
// Latency: done pulses 33 cycles after the accepting edge (WIDTH steps + sign fix-up),
//          1 cycle after it for a zero divisor. start is ignored while busy.
// Ports: clk, reset (async, active-high); bus (div_seq_if.slave): start/dividend/divisor in,
//        busy/done/div_zero/hi (remainder)/lo (quotient) out, all outputs registered.
module div_seq
    import div_seq_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic     clk,
    input  logic     reset,
    div_seq_if.slave bus
);

    localparam int             CW   = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;      // partial remainder (magnitude)
    logic [WIDTH-1:0] quot_q;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] dmag_q;     // divisor magnitude
    logic             a_neg_q;    // dividend sign
    logic             b_neg_q;    // divisor sign
    logic             dz_q;       // current operation has a zero divisor
    logic             busy_q;
    logic             done_q;
    logic             div_zero_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quot_d;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;

    // Magnitudes of the raw operands. The most negative value negates to
    // itself, which read as unsigned is exactly its magnitude.
    always_comb begin
        dvd_mag = bus.dividend[WIDTH-1] ? (~bus.dividend + 1'b1) : bus.dividend;
        dvs_mag = bus.divisor[WIDTH-1]  ? (~bus.divisor + 1'b1)  : bus.divisor;
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_i  (rem_q),
        .quot_i (quot_q),
        .dmag_i (dmag_q),
        .rem_o  (rem_d),
        .quot_o (quot_d)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quot_q     <= '0;
            dmag_q     <= '0;
            a_neg_q    <= 1'b0;
            b_neg_q    <= 1'b0;
            dz_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.divisor == '0) begin
                            // Skip the iterations; hi/lo keep the previous result.
                            dz_q    <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            a_neg_q <= bus.dividend[WIDTH-1];
                            b_neg_q <= bus.divisor[WIDTH-1];
                            quot_q  <= dvd_mag;
                            dmag_q  <= dvs_mag;
                            rem_q   <= '0;
                            cnt_q   <= '0;
                            dz_q    <= 1'b0;
                            state_q <= ST_RUN;
                        end
                    end
                end

                ST_RUN: begin
                    rem_q  <= rem_d;
                    quot_q <= quot_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        state_q <= ST_FIX;
                    end
                end

                ST_FIX: begin
                    // Quotient truncates toward zero; remainder follows the dividend sign.
                    lo_q    <= (a_neg_q ^ b_neg_q) ? (~quot_q + 1'b1) : quot_q;
                    hi_q    <= a_neg_q ? (~rem_q + 1'b1) : rem_q;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end

                ST_DONE: begin
                    if (!done_q) begin
                        // Arrived straight from IDLE on a zero divisor: raise the
                        // pulse one edge later so the flag and done appear together
                        // one cycle after the accepting edge.
                        done_q     <= 1'b1;
                        div_zero_q <= dz_q;
                    end else begin
                        done_q     <= 1'b0;
                        div_zero_q <= 1'b0;
                        busy_q     <= 1'b0;
                        dz_q       <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;

endmodule : div_seq

// File: tb/tb_div_seq.sv
// Testbench for div_seq: directed corner cases plus randomized operands checked
// against a signed-arithmetic reference model; also covers reset mid-operation
// and start requests while busy.
module tb_div_seq;

    logic clk = 1'b0;
    logic reset;

    div_seq_if #(.WIDTH(32)) dif ();

    div_seq #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Last successful result as the model sees it.
    logic [31:0] m_lo = '0;
    logic [31:0] m_hi = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Signed division with truncation toward zero; remainder takes dividend sign.
    function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [31:0] eq;
        logic [31:0] er;
        int          lat;
        int          cyc;
        bit          busy_ok;
        bit          hold_ok;
        if (b == 32'h0) begin
            eq  = m_lo;
            er  = m_hi;
            lat = 1;
        end else begin
            model(a, b, eq, er);
            lat = 33;
        end
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = a;
        dif.divisor  = b;
        @(negedge clk);
        dif.start    = 1'b0;
        dif.dividend = $urandom;
        dif.divisor  = $urandom;
        chk("busy_accept", {31'b0, dif.busy}, 32'd1);
        cyc     = 0;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        while (!dif.done && cyc < 100) begin
            if (poke && (cyc == 4 || cyc == 32)) begin
                dif.start    = 1'b1;
                dif.dividend = $urandom;
                dif.divisor  = $urandom;
            end else begin
                dif.start = 1'b0;
            end
            if (dif.lo !== m_lo || dif.hi !== m_hi) hold_ok = 1'b0;
            @(negedge clk);
            cyc++;
            if (!dif.busy) busy_ok = 1'b0;
        end
        dif.start = 1'b0;
        chk("latency", 32'(cyc), 32'(lat));
        chk("busy_hold", {31'b0, busy_ok}, 32'd1);
        chk("result_hold", {31'b0, hold_ok}, 32'd1);
        chk("div_zero", {31'b0, dif.div_zero}, {31'b0, (b == 32'h0)});
        chk("lo", dif.lo, eq);
        chk("hi", dif.hi, er);
        m_lo = eq;
        m_hi = er;
        @(negedge clk);
        chk("done_pulse", {31'b0, dif.done}, 32'd0);
        chk("busy_clear", {31'b0, dif.busy}, 32'd0);
        chk("dz_clear", {31'b0, dif.div_zero}, 32'd0);
    endtask

    task automatic reset_mid_run();
        bit no_done;
        @(negedge clk);
        dif.start    = 1'b1;
        dif.dividend = 32'd123456;
        dif.divisor  = 32'd3;
        @(negedge clk);
        dif.start = 1'b0;
        no_done   = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (dif.done) no_done = 1'b0;
        end
        reset = 1'b1;
        #1;
        chk("rst_mid_nodone", {31'b0, no_done}, 32'd1);
        chk("rst_mid_busy", {31'b0, dif.busy}, 32'd0);
        chk("rst_mid_done", {31'b0, dif.done}, 32'd0);
        chk("rst_mid_lo", dif.lo, 32'd0);
        chk("rst_mid_hi", dif.hi, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        m_lo  = '0;
        m_hi  = '0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        reset        = 1'b1;
        dif.start    = 1'b0;
        dif.dividend = '0;
        dif.divisor  = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, dif.busy}, 32'd0);
        chk("rst_done", {31'b0, dif.done}, 32'd0);
        chk("rst_dz", {31'b0, dif.div_zero}, 32'd0);
        chk("rst_lo", dif.lo, 32'd0);
        chk("rst_hi", dif.hi, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(32'd7, 32'd2, 1'b0);
        run_op(32'd5, 32'd0, 1'b0);
        run_op(32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(32'd7, 32'hFFFF_FFFE, 1'b0);
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(32'h8000_0000, 32'd1, 1'b0);
        run_op(32'h7FFF_FFFF, 32'h8000_0000, 1'b0);
        reset_mid_run();
        run_op(32'd100, 32'd7, 1'b0);
        run_op(32'd1000, 32'd9, 1'b1);
        run_op(32'hFFFF_FC18, 32'd13, 1'b0);

        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'h0;
                1:       rb = 32'hFFFF_FFFF;
                2, 3:    rb = 32'($urandom_range(1, 20));
                4:       rb = -32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) ra = 32'($urandom_range(0, 50));
            run_op(ra, rb, ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_div_seq
